// File: rtl/seven_seg_scan_if.sv
// Bus bundle between the scan controller and whatever drives its display value.
// The master side supplies the value and controls; the slave side returns the scan outputs.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 2
) ();
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic                    lz_en;
  logic [3:0]              nibble_out;
  logic [NUM_DIGITS-1:0]   digit_en_n;
  logic                    frame_tick;

  modport master (
    output value, load, lz_en,
    input  nibble_out, digit_en_n, frame_tick
  );

  modport slave (
    input  value, load, lz_en,
    output nibble_out, digit_en_n, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display scanner: one nibble and one active-low digit enable per slot,
// with frame-aligned value updates, inter-digit blanking and optional leading-zero suppression.
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  seven_seg_scan_if.slave  bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRSC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         prsc_q, prsc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         pending_q, pending_d;
  logic [VW-1:0]         active_q, active_d;
  logic [3:0]            nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  wrap;
  logic                  frame;
  logic                  blank;
  logic [NUM_DIGITS-1:0] supp;

  always_comb begin
    wrap  = (prsc_q == PRSC_MAX);
    frame = wrap && (idx_q == IDX_MAX);

    prsc_d = wrap ? '0 : prsc_q + PW'(1);
    idx_d  = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end

    // A load on the frame edge bypasses straight into the frame being started.
    pending_d    = bus.load ? bus.value : pending_q;
    active_d     = frame ? pending_d : active_q;
    frame_tick_d = frame;
  end

  // Outputs describe the post-edge state, so everything below keys off the _d values.
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    supp    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero && (active_d[4*i +: 4] == 4'h0);
      supp[i] = bus.lz_en && hi_zero;
    end
  end

  always_comb begin
    blank      = (int'(prsc_d) < BLANK_CYCLES);
    nibble_d   = '0;
    digit_en_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nibble_d = active_d[4*i +: 4];
        if (!blank && !supp[i]) begin
          digit_en_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prsc_q       <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      active_q     <= '0;
      nibble_q     <= '0;
      digit_en_q   <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      prsc_q       <= prsc_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      nibble_q     <= nibble_d;
      digit_en_q   <= digit_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.nibble_out = nibble_q;
  assign bus.digit_en_n = digit_en_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: a 2-digit instance (REFRESH_DIV=8, BLANK_CYCLES=2) and a
// 1-digit instance (BLANK_CYCLES=0) share clock, reset and the low nibble of the stimulus.
module tb_seven_seg_scan;

  localparam int ND = 2;
  localparam int RD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_if #(.NUM_DIGITS(2)) bus2 ();
  seven_seg_scan_if #(.NUM_DIGITS(1)) bus1 ();

  seven_seg_scan #(.NUM_DIGITS(2), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  seven_seg_scan #(.NUM_DIGITS(1), .REFRESH_DIV(8), .BLANK_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: n counts edges since reset release; everything else follows from it.
  int         n;
  logic [7:0] pend, act;
  logic [3:0] pend1, act1;
  logic [3:0] e_nib, e1_nib;
  logic [1:0] e_en;
  logic       e1_en, e_tick, e1_tick;

  typedef struct {
    bit       ld;
    bit [7:0] v;
    bit       lz;
    int       cnt;
    bit [3:0] nib;
    bit [1:0] en;
    bit       tick;
  } seg_t;

  seg_t tbl[32];

  function automatic seg_t mk(bit ld, bit [7:0] v, bit lz, int c, bit [3:0] nb, bit [1:0] en, bit tk);
    seg_t s;
    s.ld = ld; s.v = v; s.lz = lz; s.cnt = c; s.nib = nb; s.en = en; s.tick = tk;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s n=%0d got=%0h expected=%0h", nm, n, a, e);
    end
  endtask

  task automatic model_reset();
    n = 0; pend = '0; act = '0; pend1 = '0; act1 = '0;
  endtask

  task automatic model_step(input logic ld, input logic [7:0] v, input logic lz);
    int idx;
    int a;
    bit blank, supp;
    n++;
    if (ld) begin
      pend  = v;
      pend1 = v[3:0];
    end
    e_tick = ((n % (RD * ND)) == 0);
    if (e_tick) act = pend;
    e1_tick = ((n % RD) == 0);
    if (e1_tick) act1 = pend1;
    idx   = (n / RD) % ND;
    a     = int'(act);
    e_nib = 4'((a >> (4 * idx)) & 15);
    blank = ((n % RD) < BC);
    supp  = lz && (idx >= 1) && ((a >> (4 * idx)) == 0);
    e_en  = (blank || supp) ? 2'b11 : 2'(~(1 << idx));
    e1_nib = act1;
    e1_en  = 1'b0;
  endtask

  task automatic step(input logic ld, input logic [7:0] v, input logic lz);
    bus2.load = ld; bus2.value = v;      bus2.lz_en = lz;
    bus1.load = ld; bus1.value = v[3:0]; bus1.lz_en = lz;
    @(posedge clk);
    model_step(ld, v, lz);
    #1;
  endtask

  task automatic check_dut1();
    chk("d1_nibble", 32'(bus1.nibble_out), 32'(e1_nib));
    chk("d1_en",     32'(bus1.digit_en_n), 32'(e1_en));
    chk("d1_tick",   32'(bus1.frame_tick), 32'(e1_tick));
  endtask

  task automatic check_model();
    chk("d2_nibble", 32'(bus2.nibble_out), 32'(e_nib));
    chk("d2_en",     32'(bus2.digit_en_n), 32'(e_en));
    chk("d2_tick",   32'(bus2.frame_tick), 32'(e_tick));
    check_dut1();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_d2_nibble"}, 32'(bus2.nibble_out), 32'h0);
    chk({tag, "_d2_en"},     32'(bus2.digit_en_n), 32'h3);
    chk({tag, "_d2_tick"},   32'(bus2.frame_tick), 32'h0);
    chk({tag, "_d1_nibble"}, 32'(bus1.nibble_out), 32'h0);
    chk({tag, "_d1_en"},     32'(bus1.digit_en_n), 32'h1);
    chk({tag, "_d1_tick"},   32'(bus1.frame_tick), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog n=%0d got=running expected=finished", n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ld, lz;
    logic [7:0] v;

    // Scan/tear-free/bypass/overwrite/lz phases, one record per run of identical outputs.
    tbl[0]  = mk(1, 8'h00, 0, 1, 4'h0, 2'b11, 0);
    tbl[1]  = mk(0, 8'h00, 0, 1, 4'h0, 2'b10, 0);
    tbl[2]  = mk(1, 8'hA5, 0, 5, 4'h0, 2'b10, 0);
    tbl[3]  = mk(0, 8'h00, 0, 2, 4'h0, 2'b11, 0);
    tbl[4]  = mk(0, 8'h00, 0, 6, 4'h0, 2'b01, 0);
    tbl[5]  = mk(0, 8'h00, 0, 2, 4'h5, 2'b11, 1);
    tbl[6]  = mk(0, 8'h00, 0, 6, 4'h5, 2'b10, 0);
    tbl[7]  = mk(0, 8'h00, 0, 2, 4'hA, 2'b11, 0);
    tbl[8]  = mk(0, 8'h00, 0, 6, 4'hA, 2'b01, 0);
    tbl[9]  = mk(1, 8'h3C, 0, 2, 4'hC, 2'b11, 1);
    tbl[10] = mk(1, 8'h11, 0, 1, 4'hC, 2'b10, 0);
    tbl[11] = mk(1, 8'h22, 0, 5, 4'hC, 2'b10, 0);
    tbl[12] = mk(0, 8'h00, 0, 2, 4'h3, 2'b11, 0);
    tbl[13] = mk(0, 8'h00, 0, 6, 4'h3, 2'b01, 0);
    tbl[14] = mk(0, 8'h00, 0, 2, 4'h2, 2'b11, 1);
    tbl[15] = mk(0, 8'h00, 0, 6, 4'h2, 2'b10, 0);
    tbl[16] = mk(0, 8'h00, 0, 2, 4'h2, 2'b11, 0);
    tbl[17] = mk(0, 8'h00, 0, 6, 4'h2, 2'b01, 0);
    tbl[18] = mk(1, 8'h07, 1, 2, 4'h7, 2'b11, 1);
    tbl[19] = mk(0, 8'h00, 1, 6, 4'h7, 2'b10, 0);
    tbl[20] = mk(0, 8'h00, 1, 8, 4'h0, 2'b11, 0);
    tbl[21] = mk(1, 8'h00, 1, 2, 4'h0, 2'b11, 1);
    tbl[22] = mk(0, 8'h00, 1, 6, 4'h0, 2'b10, 0);
    tbl[23] = mk(0, 8'h00, 1, 8, 4'h0, 2'b11, 0);
    tbl[24] = mk(1, 8'h70, 1, 2, 4'h0, 2'b11, 1);
    tbl[25] = mk(0, 8'h00, 1, 6, 4'h0, 2'b10, 0);
    tbl[26] = mk(0, 8'h00, 1, 2, 4'h7, 2'b11, 0);
    tbl[27] = mk(0, 8'h00, 1, 6, 4'h7, 2'b01, 0);
    tbl[28] = mk(1, 8'h07, 0, 2, 4'h7, 2'b11, 1);
    tbl[29] = mk(0, 8'h00, 0, 6, 4'h7, 2'b10, 0);
    tbl[30] = mk(0, 8'h00, 0, 2, 4'h0, 2'b11, 0);
    tbl[31] = mk(0, 8'h00, 0, 6, 4'h0, 2'b01, 0);

    bus2.load = 1'b0; bus2.value = '0; bus2.lz_en = 1'b0;
    bus1.load = 1'b0; bus1.value = '0; bus1.lz_en = 1'b0;
    model_reset();

    #2 rst_n = 1'b0;
    #5 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 32; s++) begin
      for (int k = 0; k < tbl[s].cnt; k++) begin
        step((k == 0) ? tbl[s].ld : 1'b0, tbl[s].v, tbl[s].lz);
        chk($sformatf("tbl%0d_nibble", s), 32'(bus2.nibble_out), 32'(tbl[s].nib));
        chk($sformatf("tbl%0d_en", s),     32'(bus2.digit_en_n), 32'(tbl[s].en));
        chk($sformatf("tbl%0d_tick", s),   32'(bus2.frame_tick), 32'((k == 0) ? tbl[s].tick : 1'b0));
        check_dut1();
      end
    end

    // Display A5, then pull reset mid-slot and expect an immediate blank.
    step(1'b1, 8'hA5, 1'b0);
    check_model();
    for (int k = 0; k < 21; k++) begin
      step(1'b0, 8'h00, 1'b0);
      check_model();
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 8'hFF, 1'b0);
      check_model();
      chk("post_rst_nibble_zero", 32'(bus2.nibble_out), 32'h0);
    end

    lz = 1'b0;
    for (int k = 0; k < 800; k++) begin
      ld = ($urandom_range(0, 5) == 0);
      v  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) v[7:4] = 4'h0;
      if ($urandom_range(0, 3) == 0) v[3:0] = 4'h0;
      if ($urandom_range(0, 15) == 0) lz = ~lz;
      step(ld, v, lz);
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed scan controller that sits directly upstream of the nibble-to-segment decoder.
- Holds a multi-digit hex value and presents one nibble at a time on nibble_out, which feeds the decoder's 4-bit input.
- Drives the matching active-low common digit enable.
- Provides tear-free value updates, inter-digit blanking (anti-ghosting), optional leading-zero suppression and a per-frame tick.

Parameters:
- NUM_DIGITS, 2, number of digits scanned (legal 1..8).
- REFRESH_DIV, 1000, clock cycles per digit slot (must be >= BLANK_CYCLES+2).
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits disabled (legal 0..REFRESH_DIV-2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- value  input  4*NUM_DIGITS  hex value to display; digit i = value[4i+3:4i], digit 0 least significant.
- load  input  1  capture value into the pending register this cycle.
- lz_en  input  1  leading-zero suppression enable (sampled each cycle).
- nibble_out  output  4  nibble for the decoder, registered.
- digit_en_n  output  NUM_DIGITS  one-hot active-low digit enables, registered; all ones = blank.
- frame_tick  output  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (async assert, sync release) sets:
  - pending = 0, active = 0, prescaler = 0, idx = 0
  - nibble_out = 0, digit_en_n = all ones, frame_tick = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap edge, idx advances by 1, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary:
  - Defined as the edge where idx wraps to 0.
  - On that edge, active <= pending, and frame_tick is 1 for exactly that cycle.
  - With NUM_DIGITS=1, every slot wrap is a frame boundary.
- Load:
  - load=1 at an edge sets pending <= value. active is unchanged until the next frame boundary, so no frame ever mixes two values.
  - If load coincides with a frame boundary, the new value goes directly to both pending and active (bypass).
  - Back-to-back loads within a frame: only the last one is displayed.
- Outputs:
  - Registered, and updated on the same edge as the prescaler/idx state they describe.
  - nibble_out = active[4*idx +: 4], using the post-edge idx and active.
  - digit_en_n is all ones while prescaler < BLANK_CYCLES (post-edge value).
  - Otherwise digit_en_n has bit idx = 0 and all other bits = 1, unless the digit is suppressed.
  - nibble_out tracks the current digit even while blanked.
- Leading-zero suppression, when lz_en=1:
  - Digit i (i >= 1) is suppressed (its enable stays high) if active digits NUM_DIGITS-1 down to i are all 0.
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
  - lz_en=0 shows all digits.
  - Changing lz_en takes effect at the next edge.
- Reset mid-scan: immediately blanks the outputs; after release, scanning restarts at idx 0, prescaler 0, displaying 0.
- Widths:
  - prescaler is $clog2(REFRESH_DIV) bits.
  - idx is max(1, $clog2(NUM_DIGITS)) bits.
  - No arithmetic on value; the block only selects nibbles.
- No combinational path from any input to any output.

Test Plan (NUM_DIGITS=2, REFRESH_DIV=8, BLANK_CYCLES=2 unless stated):
- Reset/scan:
  - Stimulus: release rst_n, then load value=8'h00.
  - Required: digit_en_n=2'b11 for prescaler 0-1, then 2'b10 for 6 cycles.
  - Then 2'b11 for 2 cycles and 2'b01 for 6 cycles; the pattern repeats every 16 cycles.
  - frame_tick pulses every 16 cycles, aligned with the idx=0 slot start.
- Tear-free load:
  - Stimulus: mid-slot of digit 0, load value=8'hA5.
  - Required: nibble_out stays 0 until the next frame boundary; then digit 0 -> 4'h5 and digit 1 -> 4'hA.
- Boundary bypass and overwrite:
  - Stimulus: load 8'h3C on the frame-boundary edge.
  - Required: the frame starting that cycle shows 4'hC on digit 0.
  - Stimulus: loads 8'h11 then 8'h22 within one frame.
  - Required: the next frame shows only 8'h22.
- Leading-zero suppression:
  - Stimulus: lz_en=1, value=8'h07.
  - Required: digit 1 enable never low; digit 0 low in its non-blank cycles with nibble 4'h7.
  - Stimulus: value=8'h00.
  - Required: digit 0 shows 4'h0.
  - Stimulus: value=8'h70.
  - Required: both digits are enabled.
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously mid-slot while displaying 8'hA5.
  - Required: outputs go to digit_en_n=2'b11, nibble_out=0 without waiting for a clock edge.
  - After release, the display shows 8'h00 until a load.
- NUM_DIGITS=1, BLANK_CYCLES=0:
  - Required: digit_en_n is held at 1'b0 and frame_tick pulses every 8 cycles.
